// File: rtl/debouncer_n.sv
// Multi-channel button debouncer: two-flop synchroniser, stable-count filter,
// press/release edge pulses and a per-channel press-and-hold auto-repeat FSM.
module debouncer_n #(
  parameter int CHANNELS      = 5,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic [CHANNELS-1:0] pulse
);

  localparam int DB_W     = $clog2(STABLE_CYCLES);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RPT_LAST   = HOLD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic              s1;
    logic              s2;
    logic              lvl;
    logic              press_r;
    logic              release_r;
    logic              repeat_r;
    logic              pulse_r;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    hold_state_t       state;

    logic accept;
    logic rise;
    logic fall;
    logic lvl_next;
    logic hold_ok;
    logic rep_fire;

    assign accept   = (s2 != lvl) && (db_cnt == DB_LAST);
    assign rise     = accept && s2;
    assign fall     = accept && !s2;
    assign lvl_next = accept ? s2 : lvl;
    // A falling level or a dropped enable kills the repeat in the very cycle it happens.
    assign hold_ok  = lvl_next && repeat_en[g];
    assign rep_fire = hold_ok &&
                      (((state == DELAY)  && (hold_cnt == DELAY_LAST)) ||
                       ((state == REPEAT) && (hold_cnt == RPT_LAST)));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        lvl       <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
        pulse_r   <= 1'b0;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        state     <= IDLE;
      end else begin
        s1 <= in[g];
        s2 <= s1;

        if (s2 == lvl) begin
          db_cnt <= '0;
        end else if (accept) begin
          lvl    <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        press_r   <= rise;
        release_r <= fall;
        repeat_r  <= rep_fire;
        pulse_r   <= rise | rep_fire;

        if (!hold_ok) begin
          state    <= IDLE;
          hold_cnt <= '0;
        end else begin
          unique case (state)
            IDLE: begin
              hold_cnt <= '0;
              if (rise) state <= DELAY;
            end
            DELAY: begin
              if (hold_cnt == DELAY_LAST) begin
                hold_cnt <= '0;
                state    <= REPEAT;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            REPEAT: begin
              if (hold_cnt == RPT_LAST) hold_cnt <= '0;
              else                      hold_cnt <= hold_cnt + 1'b1;
            end
            default: begin
              state    <= IDLE;
              hold_cnt <= '0;
            end
          endcase
        end
      end
    end

    assign level[g]         = lvl;
    assign press[g]         = press_r;
    assign release_pulse[g] = release_r;
    assign repeat_pulse[g]  = repeat_r;
    assign pulse[g]         = pulse_r;
  end

endmodule

// File: tb/tb_debouncer_n.sv
// Directed bench for debouncer_n with a short debounce window and fast repeat timing.
module tb_debouncer_n;
  localparam int CH = 5;

  logic          clk200MHz;
  logic          reset;
  logic [CH-1:0] in_lvl;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] repeat_pulse;
  logic [CH-1:0] pulse;

  int n_tests = 0;
  int n_fail  = 0;

  debouncer_n #(
    .CHANNELS(CH), .STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clock(clk200MHz), .reset(reset), .in(in_lvl), .repeat_en(repeat_en),
    .level(level), .press(press), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .pulse(pulse)
  );

  initial clk200MHz = 1'b0;
  always #5 clk200MHz = ~clk200MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge: outputs settled, inputs safe to drive.
  task automatic tick();
    @(posedge clk200MHz);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int n_press;
  int n_rep;

  initial begin
    reset     = 1'b1;
    in_lvl    = '0;
    repeat_en = '0;
    idle(3);
    check("reset_outputs", {level, press, release_pulse, repeat_pulse, pulse}, 0);
    reset = 1'b0;
    idle(3);

    // clean step on ch0: level/press at edge 6, not at 5
    in_lvl[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e >= 5) begin
        check($sformatf("c0_level_e%0d", e), level[0], (e >= 6));
        check($sformatf("c0_press_e%0d", e), press[0], (e == 6));
      end
      if (e == 6) check("c0_pulse_e6", pulse[0], 1);
    end
    in_lvl[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e >= 5) begin
        check($sformatf("c0_rel_level_e%0d", e), level[0], (e < 6));
        check($sformatf("c0_release_e%0d", e), release_pulse[0], (e == 6));
      end
    end
    idle(3);

    // 3-cycle glitch on ch1 must be filtered
    in_lvl[1] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) in_lvl[1] = 1'b0;
      check($sformatf("c1_glitch_e%0d", e), {level[1], press[1], release_pulse[1]}, 0);
    end
    idle(3);

    // auto-repeat on ch2; release driven at edge 25 so level falls exactly when a repeat is due
    repeat_en[2] = 1'b1;
    in_lvl[2]    = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      check($sformatf("c2_press_e%0d", e), press[2], (e == 6));
      check($sformatf("c2_repeat_e%0d", e), repeat_pulse[2],
            (e >= 16 && e <= 28 && ((e - 16) % 3 == 0)));
      check($sformatf("c2_pulse_e%0d", e), pulse[2],
            (e == 6) || (e >= 16 && e <= 28 && ((e - 16) % 3 == 0)));
      check($sformatf("c2_release_e%0d", e), release_pulse[2], (e == 31));
      check($sformatf("c2_level_e%0d", e), level[2], (e >= 6 && e <= 30));
      if (e == 25) in_lvl[2] = 1'b0;
    end
    repeat_en[2] = 1'b0;
    idle(3);

    // ch3 held without repeat_en, then repeat_en raised mid-hold
    in_lvl[3] = 1'b1;
    n_press = 0;
    n_rep   = 0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      n_press += int'(press[3]);
      n_rep   += int'(repeat_pulse[3]);
    end
    check("c3_press_count", n_press, 1);
    check("c3_repeat_count", n_rep, 0);
    repeat_en[3] = 1'b1;
    n_press = 0;
    n_rep   = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      n_press += int'(press[3]);
      n_rep   += int'(repeat_pulse[3]);
    end
    check("c3_late_en_repeat", n_rep, 0);
    check("c3_late_en_press", n_press, 0);
    check("c3_level_held", level[3], 1);
    in_lvl[3]    = 1'b0;
    idle(8);
    repeat_en[3] = 1'b0;
    idle(2);

    // all channels together, then release only ch4
    in_lvl = 5'h1F;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e >= 5) begin
        check($sformatf("all_press_e%0d", e), press, (e == 6) ? 5'h1F : 5'h00);
        check($sformatf("all_level_e%0d", e), level, (e >= 6) ? 5'h1F : 5'h00);
      end
    end
    in_lvl = 5'h0F;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e >= 5) begin
        check($sformatf("c4_release_e%0d", e), release_pulse, (e == 6) ? 5'h10 : 5'h00);
        check($sformatf("c4_level_e%0d", e), level, (e >= 6) ? 5'h0F : 5'h1F);
        check($sformatf("c4_press_e%0d", e), press, 0);
      end
    end
    in_lvl = '0;
    idle(10);
    check("all_released", level, 0);

    // reset while ch2 is in DELAY; pin stays high through reset
    repeat_en[2] = 1'b1;
    in_lvl[2]    = 1'b1;
    idle(9);
    check("c6_level_before_rst", level[2], 1);
    #2 reset = 1'b1;
    #1 check("c6_async_clear", {level, press, release_pulse, repeat_pulse, pulse}, 0);
    idle(2);
    check("c6_held_clear", {level, press, release_pulse, repeat_pulse, pulse}, 0);
    reset = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      tick();
      check($sformatf("c6_press_e%0d", e), press[2], (e == 6));
      check($sformatf("c6_repeat_e%0d", e), repeat_pulse[2], (e == 16));
      check($sformatf("c6_level_e%0d", e), level[2], (e >= 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/debouncer_n.md
DEBOUNCER_N -- requirements
Module: debouncer_n

Interface
REQ-001 The block SHALL expose parameter CHANNELS, default 5, as the number of independent input channels (legal range 1..16).
REQ-002 The block SHALL expose parameter STABLE_CYCLES, default 1_000_000, as the consecutive clock cycles of disagreement required to accept a new level (minimum 2).
REQ-003 The block SHALL expose parameter REPEAT_DELAY, default 50_000_000, as the clock cycles from press to first auto-repeat (minimum 1).
REQ-004 The block SHALL expose parameter REPEAT_PERIOD, default 10_000_000, as the clock cycles between subsequent auto-repeats (minimum 1).
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in, input, CHANNELS bits: raw, asynchronous button or switch levels (1 = pressed).
REQ-008 The block SHALL have port repeat_en, input, CHANNELS bits: per-channel auto-repeat enable.
REQ-009 The block SHALL have port level, output, CHANNELS bits: debounced level.
REQ-010 The block SHALL have port press, output, CHANNELS bits: one-cycle pulse on each accepted 0->1 transition.
REQ-011 The block SHALL have port release, output, CHANNELS bits: one-cycle pulse on each accepted 1->0 transition.
REQ-012 The block SHALL have port repeat, output, CHANNELS bits: one-cycle auto-repeat pulse.
REQ-013 The block SHALL have port pulse, output, CHANNELS bits: press OR repeat, per bit.

Function
REQ-014 Each channel SHALL pass in through two flip-flops (s1, s2) before any other use; s2 reflects a pin change 2 edges later.
REQ-015 Each channel SHALL hold a debounce counter of width clog2(STABLE_CYCLES): s2 == level -> counter cleared to 0; s2 != level and counter == STABLE_CYCLES-1 -> level takes s2 and counter clears; otherwise the counter increments.
REQ-016 Pin-to-level latency SHALL be exactly STABLE_CYCLES+2 edges for a clean step.
REQ-017 Any disagreement shorter than STABLE_CYCLES consecutive cycles at s2 SHALL leave level unchanged and SHALL restart the count from 0 when s2 agrees again.
REQ-018 press (release) SHALL be high for exactly the one cycle in which level first reads 1 (0), registered alongside the level update.
REQ-019 Each channel SHALL run a hold FSM with states IDLE, DELAY and REPEAT, using a hold counter of width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
REQ-020 IDLE SHALL move to DELAY on press with repeat_en=1, loading the counter with 0.
REQ-021 In DELAY, counter == REPEAT_DELAY-1 SHALL assert repeat next cycle, reload the counter with 0 and enter REPEAT; otherwise the counter increments.
REQ-022 In REPEAT, counter == REPEAT_PERIOD-1 SHALL assert repeat next cycle and reload the counter with 0; otherwise the counter increments.
REQ-023 Resulting timing: first repeat REPEAT_DELAY cycles after the press cycle, then every REPEAT_PERIOD cycles while level=1 and repeat_en=1.
REQ-024 Level falling, or repeat_en low, in any state SHALL force IDLE with the counter at 0 in the same cycle; no repeat pulse SHALL be emitted in that cycle.
REQ-025 repeat_en rising while level=1 SHALL NOT start repeats; a fresh press is required.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses with no priority or loss.
REQ-027 press and repeat SHALL never be high together on one channel, so pulse needs no arbitration.

Reset
REQ-028 While reset is high, asynchronously: s1, s2, level, press, release, repeat, pulse, all counters = 0; all hold FSMs in IDLE.
REQ-029 After reset deasserts with a pin already at 1, that channel SHALL produce press after STABLE_CYCLES+2 edges, as for a fresh step.
REQ-030 Reset asserted mid-count or mid-repeat SHALL abort with no trailing pulse.

Verification (CHANNELS=5, STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-031 The bench SHALL drive in[0] from 0 to 1 at edge 0 and SHALL check press[0] and level[0] at edge 6, with press[0] low at edge 7.
REQ-032 The bench SHALL drive in[1] high for 3 cycles, then low, and SHALL check level[1], press[1] and release[1] stay 0 throughout.
REQ-033 The bench SHALL set repeat_en[2]=1, hold in[2] high, and SHALL check press[2] at cycle P, repeat[2] at P+10, P+13 and P+16, and pulse[2] mirroring them; on release it SHALL check release[2] and no further repeats.
REQ-034 The bench SHALL hold in[3] with repeat_en[3]=0 and SHALL check a single press[3] and zero repeats over 100 cycles; it SHALL then raise repeat_en[3] mid-hold and check that still no repeat occurs.
REQ-035 The bench SHALL toggle in[0..4] together and SHALL check all five press bits on the same edge; it SHALL then release only in[4] and check that only release[4] fires.
REQ-036 The bench SHALL assert reset during the DELAY state of a channel and SHALL check all outputs 0 immediately (asynchronously) and no repeat after deassertion until a new qualified press.
